// File: rtl/shot_pool_mover.sv
// shot_pool_mover: multi-slot player projectile engine with fire cooldown.
// Optional SHOT_WALL_BOUNCE_EN: one side-wall bounce per shot before retiring.
`default_nettype none

module shot_pool_mover #(
  parameter int NUM_SHOTS       = 4,
  parameter int FP_SHIFT        = 6,
  parameter int SPD_STRAIGHT    = 100,
  parameter int SPD_LATERAL     = 30,
  parameter int SPD_ANGLED      = 70,
  parameter int PU_SPD_STRAIGHT = 170,
  parameter int PU_SPD_LATERAL  = 50,
  parameter int PU_SPD_ANGLED   = 110,
  parameter int Y_MIN           = 2,
  parameter int X_MIN           = 1,
  parameter int X_MAX           = 639,
  parameter int PARK_X          = 781,
  parameter int PARK_Y          = 781,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          startOfFrame,
  input  logic                          pause,
  input  logic                          triggerShot,
  input  logic [2:0]                    shotDirection,
  input  logic                          poweredUp,
  input  logic signed [10:0]            player_topLeftX,
  input  logic signed [10:0]            player_topLeftY,
  input  logic [NUM_SHOTS-1:0]          shotCollision,
  output logic [11*NUM_SHOTS-1:0]       shotX,
  output logic [11*NUM_SHOTS-1:0]       shotY,
  output logic [NUM_SHOTS-1:0]          shotActive,
  output logic [3*NUM_SHOTS-1:0]        draw_shot_dir,
  output logic                          fireAccept,
  output logic                          poolFull
);

  localparam int SLOT_W = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
  localparam int CD_W   = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(COOLDOWN_FRAMES);
  localparam logic signed [31:0] PARK_X_FP = 32'(PARK_X) <<< FP_SHIFT;
  localparam logic signed [31:0] PARK_Y_FP = 32'(PARK_Y) <<< FP_SHIFT;
  localparam logic signed [31:0] X_MIN_FP  = 32'(X_MIN) <<< FP_SHIFT;
  localparam logic signed [31:0] X_MAX_FP  = 32'(X_MAX) <<< FP_SHIFT;

  typedef enum logic {S_IDLE = 1'b0, S_FLYING = 1'b1} slot_state_t;

  slot_state_t        r_state [NUM_SHOTS];
  logic signed [31:0] r_px    [NUM_SHOTS];
  logic signed [31:0] r_py    [NUM_SHOTS];
  logic signed [31:0] r_vx    [NUM_SHOTS];
  logic signed [31:0] r_vy    [NUM_SHOTS];
  logic [2:0]         r_dir   [NUM_SHOTS];
  logic [CD_W-1:0]    r_cd;
  logic               r_trig_d;
  logic               r_fire;

  slot_state_t        w_state_nxt [NUM_SHOTS];
  logic signed [31:0] w_px_nxt    [NUM_SHOTS];
  logic signed [31:0] w_py_nxt    [NUM_SHOTS];
  logic signed [31:0] w_vx_nxt    [NUM_SHOTS];
  logic signed [31:0] w_vy_nxt    [NUM_SHOTS];
  logic [2:0]         w_dir_nxt   [NUM_SHOTS];
  logic signed [31:0] w_nx        [NUM_SHOTS];
  logic signed [31:0] w_ny        [NUM_SHOTS];
  logic signed [31:0] w_nxp       [NUM_SHOTS];
  logic signed [31:0] w_nyp       [NUM_SHOTS];
  logic               w_retire    [NUM_SHOTS];
  logic [CD_W-1:0]    w_cd_nxt;
  logic               w_trig_rise;
  logic               w_launch;
  logic               w_alloc_ok;
  logic [SLOT_W-1:0]  w_alloc_idx;
  logic signed [31:0] w_lx;
  logic signed [31:0] w_ly;
  logic signed [31:0] w_lvx;
  logic signed [31:0] w_lvy;
  logic [2:0]         w_ldir;
  logic signed [31:0] w_spd_s;
  logic signed [31:0] w_spd_l;
  logic signed [31:0] w_spd_a;

`ifdef SHOT_WALL_BOUNCE_EN
  logic r_bounced     [NUM_SHOTS];
  logic w_bounced_nxt [NUM_SHOTS];
`endif

  assign w_trig_rise = triggerShot & ~r_trig_d;
  assign w_lx = {{21{player_topLeftX[10]}}, player_topLeftX} <<< FP_SHIFT;
  assign w_ly = {{21{player_topLeftY[10]}}, player_topLeftY} <<< FP_SHIFT;
  assign w_spd_s = poweredUp ? 32'(PU_SPD_STRAIGHT) : 32'(SPD_STRAIGHT);
  assign w_spd_l = poweredUp ? 32'(PU_SPD_LATERAL)  : 32'(SPD_LATERAL);
  assign w_spd_a = poweredUp ? 32'(PU_SPD_ANGLED)   : 32'(SPD_ANGLED);

  always_comb begin
    w_lvx  = '0;
    w_lvy  = w_spd_s;
    w_ldir = 3'b010;
    case (shotDirection)
      3'b001: begin w_lvx = w_spd_l;  w_lvy = w_spd_a; w_ldir = 3'b001; end
      3'b100: begin w_lvx = -w_spd_l; w_lvy = w_spd_a; w_ldir = 3'b100; end
      default: ;
    endcase
  end

  // Lowest-index idle slot wins; uses registered state, so a slot retiring
  // this cycle only becomes allocatable next cycle.
  always_comb begin
    w_alloc_ok  = 1'b0;
    w_alloc_idx = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (r_state[i] == S_IDLE) begin
        w_alloc_ok  = 1'b1;
        w_alloc_idx = SLOT_W'(i);
      end
    end
  end

  assign w_launch = w_trig_rise && !pause && (r_cd == '0) && w_alloc_ok;

  always_comb begin
    w_cd_nxt = r_cd;
    if (w_launch)
      w_cd_nxt = CD_LOAD;
    else if (startOfFrame && !pause && (r_cd != '0))
      w_cd_nxt = r_cd - CD_W'(1);
  end

  always_comb begin
    for (int i = 0; i < NUM_SHOTS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_px_nxt[i]    = r_px[i];
      w_py_nxt[i]    = r_py[i];
      w_vx_nxt[i]    = r_vx[i];
      w_vy_nxt[i]    = r_vy[i];
      w_dir_nxt[i]   = r_dir[i];
      w_retire[i]    = 1'b0;
`ifdef SHOT_WALL_BOUNCE_EN
      w_bounced_nxt[i] = r_bounced[i];
`endif
      w_ny[i]  = r_py[i] - r_vy[i];
      w_nx[i]  = r_px[i] + r_vx[i];
      w_nyp[i] = w_ny[i] >>> FP_SHIFT;
      w_nxp[i] = w_nx[i] >>> FP_SHIFT;

      if (r_state[i] == S_IDLE) begin
        if (w_launch && (w_alloc_idx == SLOT_W'(i))) begin
          w_state_nxt[i] = S_FLYING;
          w_px_nxt[i]    = w_lx;
          w_py_nxt[i]    = w_ly;
          w_vx_nxt[i]    = w_lvx;
          w_vy_nxt[i]    = w_lvy;
          w_dir_nxt[i]   = w_ldir;
`ifdef SHOT_WALL_BOUNCE_EN
          w_bounced_nxt[i] = 1'b0;
`endif
        end
      end else begin
        if (shotCollision[i]) begin
          w_retire[i] = 1'b1;
        end else if (startOfFrame && !pause) begin
          if (w_nyp[i] < Y_MIN) begin
            w_retire[i] = 1'b1;
          end else if ((w_nxp[i] < X_MIN) || (w_nxp[i] > X_MAX)) begin
`ifdef SHOT_WALL_BOUNCE_EN
            if (r_bounced[i]) begin
              w_retire[i] = 1'b1;
            end else begin
              w_bounced_nxt[i] = 1'b1;
              w_vx_nxt[i]      = -r_vx[i];
              w_px_nxt[i]      = (w_nxp[i] < X_MIN) ? X_MIN_FP : X_MAX_FP;
              w_py_nxt[i]      = w_ny[i];
            end
`else
            w_retire[i] = 1'b1;
`endif
          end else begin
            w_px_nxt[i] = w_nx[i];
            w_py_nxt[i] = w_ny[i];
          end
        end
      end

      if (w_retire[i]) begin
        w_state_nxt[i] = S_IDLE;
        w_px_nxt[i]    = PARK_X_FP;
        w_py_nxt[i]    = PARK_Y_FP;
        w_vx_nxt[i]    = '0;
        w_vy_nxt[i]    = '0;
        w_dir_nxt[i]   = 3'b000;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_SHOTS; i++) begin
        r_state[i] <= S_IDLE;
        r_px[i]    <= PARK_X_FP;
        r_py[i]    <= PARK_Y_FP;
        r_vx[i]    <= '0;
        r_vy[i]    <= '0;
        r_dir[i]   <= 3'b000;
`ifdef SHOT_WALL_BOUNCE_EN
        r_bounced[i] <= 1'b0;
`endif
      end
      r_cd     <= '0;
      r_trig_d <= 1'b0;
      r_fire   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SHOTS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_px[i]    <= w_px_nxt[i];
        r_py[i]    <= w_py_nxt[i];
        r_vx[i]    <= w_vx_nxt[i];
        r_vy[i]    <= w_vy_nxt[i];
        r_dir[i]   <= w_dir_nxt[i];
`ifdef SHOT_WALL_BOUNCE_EN
        r_bounced[i] <= w_bounced_nxt[i];
`endif
      end
      r_cd     <= w_cd_nxt;
      r_trig_d <= triggerShot;
      r_fire   <= w_launch;
    end
  end

  generate
    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_out
      assign shotX[11*g +: 11]        = r_px[g][FP_SHIFT +: 11];
      assign shotY[11*g +: 11]        = r_py[g][FP_SHIFT +: 11];
      assign shotActive[g]            = (r_state[g] == S_FLYING);
      assign draw_shot_dir[3*g +: 3]  = r_dir[g];
    end
  endgenerate

  assign fireAccept = r_fire;
  assign poolFull   = &shotActive;

endmodule

`default_nettype wire
